dedicated_proc_param: RTL and testbench

DEDICATED_PROC_PARAM -- requirements
Module: dedicated_proc_param

---
 rtl/dedicated_proc_pkg.sv | 5 +
 rtl/dp_datapath.sv | 63 ++++++
 rtl/dedicated_proc_param.sv | 72 +++++++
 tb/tb_dedicated_proc_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dedicated_proc_pkg.sv
// dedicated_proc_pkg: shared state and mode encodings for the accumulate processor
package dedicated_proc_pkg;
    typedef enum logic [2:0] {IDLE, INIT, CHECK, ADD, INCR, DONE} state_t;
    typedef enum logic {MODE_SUM = 1'b0, MODE_ODD = 1'b1} mode_t;
endpackage

// File: rtl/dp_datapath.sv
// dp_datapath: loop counter, limit/mode latch, saturating accumulator and output register
module dp_datapath
    import dedicated_proc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              init,
    input  logic              add,
    input  logic              incr,
    input  logic              mode,
    input  logic [DATA_W-1:0] n_in,
    output logic              i_le_limit,
    output logic [DATA_W-1:0] outPort,
    output logic              ovf
);
    logic [DATA_W:0]   i;
    logic [DATA_W-1:0] limit;
    logic [DATA_W-1:0] acc;
    mode_t             mode_r;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] acc_next;
    logic              take;

    // i is one bit wider than the limit so N = all-ones still ends the loop
    assign i_le_limit = i <= {1'b0, limit};
    // In ADD, i never exceeds the DATA_W-bit limit, so its top bit is zero there
    assign sum        = {1'b0, acc} + {1'b0, i[DATA_W-1:0]};
    assign take       = (mode_r == MODE_SUM) || i[0];
    // Once saturated the accumulator is pinned to all-ones for the rest of the run
    assign acc_next   = (ovf || sum[DATA_W]) ? '1 : sum[DATA_W-1:0];

    // Register updates driven by the control strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            i       <= '0;
            limit   <= '0;
            acc     <= '0;
            mode_r  <= MODE_SUM;
            outPort <= '0;
            ovf     <= 1'b0;
        end else begin
            if (load) begin
                limit  <= n_in;
                mode_r <= mode_t'(mode);
            end
            if (init) begin
                i       <= (DATA_W+1)'(1);
                acc     <= '0;
                outPort <= '0;
                ovf     <= 1'b0;
            end
            if (add && take) begin
                acc     <= acc_next;
                outPort <= acc_next;
                ovf     <= ovf | sum[DATA_W];
            end
            if (incr) i <= i + 1'b1;
        end
    end
endmodule

// File: rtl/dedicated_proc_param.sv
// dedicated_proc_param: control FSM sequencing a summation loop over 1..N
module dedicated_proc_param
    import dedicated_proc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] n_in,
    output logic [DATA_W-1:0] outPort,
    output logic              busy,
    output logic              done,
    output logic              ovf
);
    state_t state, state_next;
    logic   load, init, add, incr, i_le_limit;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and control strobe decode
    always_comb begin
        state_next = state;
        load       = 1'b0;
        init       = 1'b0;
        add        = 1'b0;
        incr       = 1'b0;
        case (state)
            IDLE: begin
                load       = start;
                state_next = start ? INIT : IDLE;
            end
            INIT: begin
                init       = 1'b1;
                state_next = CHECK;
            end
            CHECK: state_next = i_le_limit ? ADD : DONE;
            ADD: begin
                add        = 1'b1;
                state_next = INCR;
            end
            INCR: begin
                incr       = 1'b1;
                state_next = CHECK;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

    dp_datapath #(.DATA_W(DATA_W)) u_dp (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .init       (init),
        .add        (add),
        .incr       (incr),
        .mode       (mode),
        .n_in       (n_in),
        .i_le_limit (i_le_limit),
        .outPort    (outPort),
        .ovf        (ovf)
    );
endmodule

// File: tb/tb_dedicated_proc_param.sv
// tb_dedicated_proc_param: vector table, hand sequences and randomized runs against a closed-form model
module tb_dedicated_proc_param;
    localparam int DATA_W = 8;
    localparam int MAXV   = (1 << DATA_W) - 1;

    typedef struct {
        int n;
        bit m;
        int exp_out;
        bit exp_ovf;
        int exp_lat;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [DATA_W-1:0] n_in = '0;
    logic [DATA_W-1:0] outPort;
    logic              busy, done, ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    dedicated_proc_param #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .n_in    (n_in),
        .outPort (outPort),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Closed-form result: sum of 1..N is N(N+1)/2, sum of odd numbers up to N is k^2 with k=(N+1)/2
    function automatic void model(input int n, input bit m, output int out, output bit ov);
        longint k, t;
        k   = (n + 1) / 2;
        t   = m ? k * k : longint'(n) * (n + 1) / 2;
        ov  = t > MAXV;
        out = ov ? MAXV : int'(t);
    endfunction

    task automatic launch(input int n, input bit m);
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = DATA_W'(n);
        mode  = m;
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit bok);
        bok = 1'b1;
        lat = -1;
        forever begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t0;
                break;
            end
            if (!busy) bok = 1'b0;
            if (cyc - t0 > 2000) begin
                chk("done_timeout", done, 1);
                break;
            end
        end
    endtask

    task automatic do_run(input string tag, input int n, input bit m, input int eo, input bit eov, input int elat);
        int lat;
        bit bok;
        launch(n, m);
        wait_done(lat, bok);
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_out"}, outPort, eo);
        chk({tag, "_ovf"}, ovf, eov);
        chk({tag, "_busy_run"}, bok, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_out_hold"}, outPort, eo);
    endtask

    initial begin
        vec_t vecs[8];
        int   lat, eo;
        bit   bok, eov;
        vecs[0] = '{10, 1'b0, 55, 1'b0, 33};
        vecs[1] = '{10, 1'b1, 25, 1'b0, 33};
        vecs[2] = '{0, 1'b0, 0, 1'b0, 3};
        vecs[3] = '{1, 1'b1, 1, 1'b0, 6};
        vecs[4] = '{2, 1'b1, 1, 1'b0, 9};
        vecs[5] = '{255, 1'b0, 255, 1'b1, 768};
        vecs[6] = '{22, 1'b0, 253, 1'b0, 69};
        vecs[7] = '{23, 1'b0, 255, 1'b1, 72};

        // Reset with start asserted: reset must win
        start = 1'b1;
        n_in  = 8'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", outPort, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        for (int v = 0; v < 8; v++)
            do_run($sformatf("vec%0d", v), vecs[v].n, vecs[v].m, vecs[v].exp_out, vecs[v].exp_ovf, vecs[v].exp_lat);

        // Start re-pulsed with other inputs while busy is ignored; ovf from previous run cleared
        launch(10, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        n_in  = 8'd3;
        mode  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bok);
        chk("repulse_latency", lat, 33);
        chk("repulse_out", outPort, 55);
        chk("repulse_ovf", ovf, 0);
        do_run("after_repulse", 3, 1'b0, 6, 1'b0, 12);

        // Reset in cycle 12 of an N=10 run abandons it without a done pulse
        launch(10, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_out_before_rst", outPort, 6);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out", outPort, 0);
        chk("midrst_ovf", ovf, 0);
        bok = 1'b1;
        repeat (40) begin
            if (done || busy) bok = 1'b0;
            @(negedge clk);
        end
        chk("midrst_quiet", bok, 1);
        do_run("after_midrst", 4, 1'b0, 10, 1'b0, 15);

        // Start held high through DONE starts a second run right away
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = 8'd2;
        mode  = 1'b0;
        t0    = cyc;
        @(posedge clk); #1;
        n_in  = 8'd3;
        wait_done(lat, bok);
        chk("b2b_first_latency", lat, 9);
        chk("b2b_first_out", outPort, 3);
        @(posedge clk); #1;
        t0 = cyc;
        @(negedge clk);
        chk("b2b_idle_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bok);
        chk("b2b_second_latency", lat, 12);
        chk("b2b_second_out", outPort, 6);
        chk("b2b_second_busy", bok, 1);

        // Randomized runs checked against the closed-form model
        for (int r = 0; r < 12; r++) begin
            int n;
            bit m;
            n = int'($urandom_range(0, 40));
            m = 1'($urandom_range(0, 1));
            model(n, m, eo, eov);
            do_run($sformatf("rand%0d_n%0d_m%0d", r, n, m), n, m, eo, eov, 3 * n + 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
